// File: rtl/onchip_flash_pkg.sv
// ============================================================================
//  Module : onchip_flash_pkg
//  Brief  : Shared encodings, status layout, control-word helpers and the FSM
//           state type for the on-chip flash Avalon-MM master.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

package onchip_flash_pkg;

   localparam logic [1:0] c_op_read  = 2'd0;
   localparam logic [1:0] c_op_write = 2'd1;
   localparam logic [1:0] c_op_erase = 2'd2;
   localparam logic [1:0] c_op_rsvd  = 2'd3;

   localparam int ST_READ_OK  = 2;
   localparam int ST_WRITE_OK = 3;
   localparam int ST_ERASE_OK = 4;

   localparam logic [1:0] BUSY_IDLE = 2'b00;

   localparam logic [31:0] CTRL_SAFE_DEFAULT = 32'hFFFF_FFFF;
   localparam int          WP_BASE           = 23;
   localparam int          ERASE_SEC_LSB     = 20;

   typedef enum logic [3:0] {
      S_IDLE        = 4'd0,
      S_PRE_POLL    = 4'd1,
      S_UNPROT      = 4'd2,
      S_RD_REQ      = 4'd3,
      S_RD_BEATS    = 4'd4,
      S_WR          = 4'd5,
      S_ERASE_ISSUE = 4'd6,
      S_POST_POLL   = 4'd7,
      S_REPROT      = 4'd8,
      S_RESP        = 4'd9
   } state_t;

   // Sector n (1..5) owns write-protect bit WP_BASE + n - 1.
   function automatic logic [31:0] f_unprot(input logic [31:0] ctrl, input logic [2:0] sector);
      logic [31:0] w_word;
      logic [4:0]  w_bit;
      w_word        = ctrl;
      w_bit         = 5'(WP_BASE - 1) + {2'b00, sector};
      w_word[w_bit] = 1'b0;
      return w_word;
   endfunction

   function automatic logic [31:0] f_erase(input logic [31:0] ctrl, input logic [2:0] sector);
      logic [31:0] w_word;
      w_word                       = f_unprot(ctrl, sector);
      w_word[ERASE_SEC_LSB +: 3]   = sector;
      return w_word;
   endfunction

endpackage

`default_nettype wire

// File: rtl/flash_csr_poller.sv
// ============================================================================
//  Module : flash_csr_poller
//  Brief  : Issues status reads on the flash CSR port until the controller is
//           idle, with optional settle-discard of the first sample and timeout.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module flash_csr_poller
   import onchip_flash_pkg::*;
#(
   parameter int unsigned POLL_LIMIT = 1048576
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_start,
   input  logic        i_is_post,
   input  logic [31:0] i_csr_readdata,
   output logic        o_csr_read,
   output logic        o_done,
   output logic        o_timeout,
   output logic [31:0] o_status
);

   localparam int            CW      = $clog2(POLL_LIMIT + 1);
   localparam logic [CW-1:0] c_limit = CW'(POLL_LIMIT);

   logic          r_active;
   logic          r_sample;
   logic          r_discard;
   logic [CW-1:0] r_cnt;
   logic          w_idle;
   logic          w_at_limit;

   assign w_idle     = (i_csr_readdata[1:0] == BUSY_IDLE);
   assign w_at_limit = (r_cnt >= c_limit);
   assign o_csr_read = r_active & ~r_sample;
   assign o_done     = r_active & r_sample & ~r_discard & w_idle;
   assign o_timeout  = r_active & r_sample & ~o_done & w_at_limit;
   assign o_status   = i_csr_readdata;

   // Read/sample alternate; r_cnt counts every read issued, discarded or not.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_active  <= 1'b0;
         r_sample  <= 1'b0;
         r_discard <= 1'b0;
         r_cnt     <= '0;
      end else if (i_start) begin
         r_active  <= 1'b1;
         r_sample  <= 1'b0;
         r_discard <= i_is_post;
         r_cnt     <= '0;
      end else if (r_active) begin
         if (!r_sample) begin
            r_sample <= 1'b1;
            r_cnt    <= r_cnt + CW'(1);
         end else begin
            r_sample  <= 1'b0;
            r_discard <= 1'b0;
            if (o_done || o_timeout) begin
               r_active <= 1'b0;
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/onchip_flash_master.sv
// ============================================================================
//  Module : onchip_flash_master
//  Brief  : Avalon-MM host sequencing READ/WRITE/ERASE commands onto the MAX10
//           on-chip flash data and CSR ports, including protect handling.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module onchip_flash_master
   import onchip_flash_pkg::*;
#(
   parameter int unsigned MAX_BURST  = 8,
   parameter int unsigned POLL_LIMIT = 1048576,
   parameter logic [31:0] CTRL_SAFE  = CTRL_SAFE_DEFAULT
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_op,
   input  logic [16:0] cmd_addr,
   input  logic [2:0]  cmd_sector,
   input  logic [3:0]  cmd_len,
   input  logic [31:0] cmd_wdata,
   output logic        rd_valid,
   output logic [31:0] rd_data,
   output logic        done,
   output logic        error,
   output logic [16:0] avm_data_addr,
   output logic        avm_data_read,
   output logic        avm_data_write,
   output logic [31:0] avm_data_writedata,
   output logic [3:0]  avm_data_burstcount,
   input  logic [31:0] avm_data_readdata,
   input  logic        avm_data_waitrequest,
   input  logic        avm_data_readdatavalid,
   output logic        avm_csr_addr,
   output logic        avm_csr_read,
   output logic        avm_csr_write,
   output logic [31:0] avm_csr_writedata,
   input  logic [31:0] avm_csr_readdata
);

   localparam logic [3:0] c_max_len = 4'(MAX_BURST);

   state_t      r_state;
   state_t      w_state_next;
   logic [1:0]  r_op;
   logic [16:0] r_addr;
   logic [2:0]  r_sector;
   logic [3:0]  r_len;
   logic [31:0] r_wdata;
   logic        r_err;
   logic [3:0]  r_beat;

   logic        w_bad;
   logic        w_accept;
   logic        w_err_set;
   logic        w_poll_start;
   logic        w_poll_post;
   logic        w_poll_done;
   logic        w_poll_timeout;
   logic [31:0] w_status;
   logic        w_unused_status;

   flash_csr_poller #(
      .POLL_LIMIT (POLL_LIMIT)
   ) u_poller (
      .clk            (clock),
      .rst            (reset),
      .i_start        (w_poll_start),
      .i_is_post      (w_poll_post),
      .i_csr_readdata (avm_csr_readdata),
      .o_csr_read     (avm_csr_read),
      .o_done         (w_poll_done),
      .o_timeout      (w_poll_timeout),
      .o_status       (w_status)
   );

   assign w_unused_status = ^{w_status[31:5], w_status[ST_READ_OK], w_status[1:0]};

   assign w_bad = (cmd_op == c_op_rsvd) ||
                  ((cmd_op == c_op_read) && ((cmd_len == 4'd0) || (cmd_len > c_max_len))) ||
                  ((cmd_op != c_op_read) && ((cmd_sector == 3'd0) || (cmd_sector > 3'd5)));

   assign w_accept  = (r_state == S_IDLE) && cmd_valid;
   assign cmd_ready = (r_state == S_IDLE);
   assign rd_valid  = (r_state == S_RD_BEATS) && avm_data_readdatavalid;
   assign rd_data   = avm_data_readdata;
   assign done      = (r_state == S_RESP);
   assign error     = (r_state == S_RESP) && r_err;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_op     <= c_op_read;
         r_addr   <= '0;
         r_sector <= '0;
         r_len    <= '0;
         r_wdata  <= '0;
         r_err    <= 1'b0;
         r_beat   <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_accept) begin
            r_op     <= cmd_op;
            r_addr   <= cmd_addr;
            r_sector <= cmd_sector;
            r_len    <= cmd_len;
            r_wdata  <= cmd_wdata;
            r_err    <= w_bad;
         end else if (w_err_set) begin
            r_err <= 1'b1;
         end
         if (r_state == S_RD_REQ) begin
            r_beat <= '0;
         end else if (rd_valid) begin
            r_beat <= r_beat + 4'd1;
         end
      end
   end

   always_comb begin
      w_state_next        = r_state;
      w_poll_start        = 1'b0;
      w_poll_post         = 1'b0;
      w_err_set           = 1'b0;
      avm_data_addr       = '0;
      avm_data_read       = 1'b0;
      avm_data_write      = 1'b0;
      avm_data_writedata  = '0;
      avm_data_burstcount = '0;
      avm_csr_addr        = 1'b0;
      avm_csr_write       = 1'b0;
      avm_csr_writedata   = '0;
      case (r_state)
         S_IDLE: begin
            if (cmd_valid) begin
               w_state_next = w_bad ? S_RESP : S_PRE_POLL;
               w_poll_start = ~w_bad;
            end
         end
         // A pre-poll timeout still re-protects WRITE/ERASE so the part is left safe.
         S_PRE_POLL: begin
            if (w_poll_done) begin
               w_state_next = (r_op == c_op_read) ? S_RD_REQ : S_UNPROT;
            end else if (w_poll_timeout) begin
               w_err_set    = 1'b1;
               w_state_next = (r_op == c_op_read) ? S_RESP : S_REPROT;
            end
         end
         S_UNPROT: begin
            avm_csr_addr      = 1'b1;
            avm_csr_write     = 1'b1;
            avm_csr_writedata = f_unprot(CTRL_SAFE, r_sector);
            w_state_next      = (r_op == c_op_write) ? S_WR : S_ERASE_ISSUE;
         end
         S_RD_REQ: begin
            avm_data_read       = 1'b1;
            avm_data_addr       = r_addr;
            avm_data_burstcount = r_len;
            if (!avm_data_waitrequest) begin
               w_state_next = S_RD_BEATS;
            end
         end
         S_RD_BEATS: begin
            if (rd_valid && (r_beat == r_len - 4'd1)) begin
               w_state_next = S_RESP;
            end
         end
         S_WR: begin
            avm_data_write     = 1'b1;
            avm_data_addr      = r_addr;
            avm_data_writedata = r_wdata;
            if (!avm_data_waitrequest) begin
               w_state_next = S_POST_POLL;
               w_poll_start = 1'b1;
               w_poll_post  = 1'b1;
            end
         end
         S_ERASE_ISSUE: begin
            avm_csr_addr      = 1'b1;
            avm_csr_write     = 1'b1;
            avm_csr_writedata = f_erase(CTRL_SAFE, r_sector);
            w_state_next      = S_POST_POLL;
            w_poll_start      = 1'b1;
            w_poll_post       = 1'b1;
         end
         S_POST_POLL: begin
            if (w_poll_done) begin
               w_err_set    = (r_op == c_op_write) ? ~w_status[ST_WRITE_OK] : ~w_status[ST_ERASE_OK];
               w_state_next = S_REPROT;
            end else if (w_poll_timeout) begin
               w_err_set    = 1'b1;
               w_state_next = S_REPROT;
            end
         end
         S_REPROT: begin
            avm_csr_addr      = 1'b1;
            avm_csr_write     = 1'b1;
            avm_csr_writedata = CTRL_SAFE;
            w_state_next      = S_RESP;
         end
         S_RESP: begin
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_onchip_flash_master.sv
// ============================================================================
//  Module : tb_onchip_flash_master
//  Brief  : Directed self-checking bench with Avalon data/CSR slave models.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_onchip_flash_master;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [1:0]  cmd_op = '0;
   logic [16:0] cmd_addr = '0;
   logic [2:0]  cmd_sector = '0;
   logic [3:0]  cmd_len = '0;
   logic [31:0] cmd_wdata = '0;
   logic        rd_valid;
   logic [31:0] rd_data;
   logic        done;
   logic        error;
   logic [16:0] avm_data_addr;
   logic        avm_data_read;
   logic        avm_data_write;
   logic [31:0] avm_data_writedata;
   logic [3:0]  avm_data_burstcount;
   logic [31:0] avm_data_readdata = '0;
   logic        avm_data_waitrequest = 1'b0;
   logic        avm_data_readdatavalid = 1'b0;
   logic        avm_csr_addr;
   logic        avm_csr_read;
   logic        avm_csr_write;
   logic [31:0] avm_csr_writedata;
   logic [31:0] avm_csr_readdata = '0;

   onchip_flash_master #(
      .MAX_BURST  (8),
      .POLL_LIMIT (16),
      .CTRL_SAFE  (32'hFFFF_FFFF)
   ) dut (
      .clock                  (clock),
      .reset                  (reset),
      .cmd_valid              (cmd_valid),
      .cmd_ready              (cmd_ready),
      .cmd_op                 (cmd_op),
      .cmd_addr               (cmd_addr),
      .cmd_sector             (cmd_sector),
      .cmd_len                (cmd_len),
      .cmd_wdata              (cmd_wdata),
      .rd_valid               (rd_valid),
      .rd_data                (rd_data),
      .done                   (done),
      .error                  (error),
      .avm_data_addr          (avm_data_addr),
      .avm_data_read          (avm_data_read),
      .avm_data_write         (avm_data_write),
      .avm_data_writedata     (avm_data_writedata),
      .avm_data_burstcount    (avm_data_burstcount),
      .avm_data_readdata      (avm_data_readdata),
      .avm_data_waitrequest   (avm_data_waitrequest),
      .avm_data_readdatavalid (avm_data_readdatavalid),
      .avm_csr_addr           (avm_csr_addr),
      .avm_csr_read           (avm_csr_read),
      .avm_csr_write          (avm_csr_write),
      .avm_csr_writedata      (avm_csr_writedata),
      .avm_csr_readdata       (avm_csr_readdata)
   );

   always #5 clock = ~clock;

   int          n_cmp = 0;
   int          n_err = 0;

   logic [31:0] status_q[$];
   logic [31:0] csr_wr_q[$];
   logic [31:0] rd_q[$];
   int          csr_rd_cnt, wait_left, wait_seen, acc_cnt, beats_left, beat_idx;
   int          done_cnt, bus_act, overlap_cnt, bad_addr, err_nodone;
   logic        csr_pending = 1'b0;
   logic        last_err;
   logic [31:0] beat_base, acc_addr, acc_burst, acc_wdata;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Slave models drive at the falling edge, then sample what the DUT will act on.
   always @(negedge clock) begin
      avm_data_waitrequest = (wait_left > 0);
      if (beats_left > 0) begin
         avm_data_readdatavalid = 1'b1;
         avm_data_readdata      = beat_base + 32'(beat_idx);
      end else begin
         avm_data_readdatavalid = 1'b0;
         avm_data_readdata      = '0;
      end
      if (csr_pending && status_q.size() > 0) begin
         avm_csr_readdata = status_q[0];
         if (status_q.size() > 1) void'(status_q.pop_front());
      end
      csr_pending = 1'b0;
      #1;
      if (avm_data_readdatavalid) begin
         beats_left--;
         beat_idx++;
      end
      if (rd_valid) rd_q.push_back(rd_data);
      if (avm_csr_read || avm_csr_write || avm_data_read || avm_data_write) bus_act++;
      if (avm_csr_read) begin
         csr_rd_cnt++;
         csr_pending = 1'b1;
         if (avm_csr_addr != 1'b0) bad_addr++;
      end
      if (avm_csr_write) begin
         csr_wr_q.push_back(avm_csr_writedata);
         if (avm_csr_addr != 1'b1) bad_addr++;
      end
      if ((avm_csr_read || avm_csr_write) && (avm_data_read || avm_data_write)) overlap_cnt++;
      if (avm_csr_read && avm_csr_write) overlap_cnt++;
      if (avm_data_read || avm_data_write) begin
         if (avm_data_waitrequest) begin
            wait_left--;
            wait_seen++;
         end else begin
            acc_cnt++;
            acc_addr = 32'(avm_data_addr);
            if (avm_data_read) begin
               acc_burst  = 32'(avm_data_burstcount);
               beats_left = int'(avm_data_burstcount);
               beat_idx   = 0;
            end else begin
               acc_wdata = avm_data_writedata;
            end
         end
      end
      if (done) begin
         done_cnt++;
         last_err = error;
      end
      if (error && !done) err_nodone++;
   end

   task automatic clear(input int waits, input logic [31:0] base);
      csr_wr_q.delete();
      rd_q.delete();
      csr_rd_cnt = 0;
      wait_left  = waits;
      wait_seen  = 0;
      acc_cnt    = 0;
      done_cnt   = 0;
      bus_act    = 0;
      last_err   = 1'bx;
      beat_base  = base;
      acc_addr   = '0;
      acc_burst  = '0;
      acc_wdata  = '0;
   endtask

   task automatic issue(input logic [1:0] op, input logic [16:0] addr, input logic [2:0] sec,
                        input logic [3:0] len, input logic [31:0] wd);
      @(negedge clock);
      cmd_op     = op;
      cmd_addr   = addr;
      cmd_sector = sec;
      cmd_len    = len;
      cmd_wdata  = wd;
      cmd_valid  = 1'b1;
      @(negedge clock);
      cmd_valid  = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (done_cnt > 0) break;
         @(negedge clock);
         #2;
      end
      chk({tag, "_done_seen"}, 32'(done_cnt), 32'd1);
   endtask

   logic [1:0] inv_op [5] = '{2'd3, 2'd0, 2'd0, 2'd1, 2'd2};
   logic [3:0] inv_len[5] = '{4'd1, 4'd0, 4'd9, 4'd1, 4'd1};
   logic [2:0] inv_sec[5] = '{3'd1, 3'd1, 3'd1, 3'd0, 3'd6};

   initial begin
      overlap_cnt = 0;
      bad_addr    = 0;
      err_nodone  = 0;
      beats_left  = 0;
      beat_idx    = 0;
      clear(0, 32'h0);
      status_q = '{32'h0};
      repeat (3) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      #2;
      chk("rst_ready", 32'(cmd_ready), 32'd1);
      chk("rst_strobes", 32'({avm_data_read, avm_data_write, avm_csr_read, avm_csr_write,
                               rd_valid, done, error}), 32'd0);
      chk("rst_addr_burst", {11'd0, avm_data_addr, avm_data_burstcount}, 32'd0);

      // READ burst of 4 with two waitrequest cycles
      clear(2, 32'hA0);
      status_q = '{32'h0};
      issue(2'd0, 17'h00100, 3'd1, 4'd4, 32'h0);
      wait_done("rd4", 100);
      chk("rd4_err", 32'(last_err), 32'd0);
      chk("rd4_nbeats", 32'(rd_q.size()), 32'd4);
      for (int i = 0; i < 4; i++)
         chk("rd4_beat", (rd_q.size() > i) ? rd_q[i] : 32'hDEAD_0000, 32'hA0 + 32'(i));
      chk("rd4_waits", 32'(wait_seen), 32'd2);
      chk("rd4_addr", acc_addr, 32'h100);
      chk("rd4_burst", acc_burst, 32'd4);
      chk("rd4_csr_wr", 32'(csr_wr_q.size()), 32'd0);

      // READ at the burst ceiling
      clear(0, 32'hC0);
      status_q = '{32'h0};
      issue(2'd0, 17'h1FFF8, 3'd1, 4'd8, 32'h0);
      wait_done("rd8", 100);
      chk("rd8_err", 32'(last_err), 32'd0);
      chk("rd8_nbeats", 32'(rd_q.size()), 32'd8);
      chk("rd8_last", (rd_q.size() == 8) ? rd_q[7] : 32'h0, 32'hC7);

      // WRITE sector 2: busy for 5 reads, then write_ok
      clear(0, 32'h0);
      status_q = '{32'h2, 32'h2, 32'h2, 32'h2, 32'h2, 32'h8};
      issue(2'd1, 17'h08000, 3'd2, 4'd1, 32'hDEADBEEF);
      wait_done("wr", 200);
      chk("wr_err", 32'(last_err), 32'd0);
      chk("wr_ncsr", 32'(csr_wr_q.size()), 32'd2);
      chk("wr_unprot", (csr_wr_q.size() > 0) ? csr_wr_q[0] : 32'h0, 32'hFEFF_FFFF);
      chk("wr_reprot", (csr_wr_q.size() > 1) ? csr_wr_q[1] : 32'h0, 32'hFFFF_FFFF);
      chk("wr_addr", acc_addr, 32'h8000);
      chk("wr_data", acc_wdata, 32'hDEADBEEF);
      chk("wr_status_reads", 32'(csr_rd_cnt), 32'd8);

      // ERASE sector 3: first post sample looks idle/failed and must be ignored
      clear(0, 32'h0);
      status_q = '{32'h0, 32'h0, 32'h1, 32'h1, 32'h1, 32'h1, 32'h1,
                   32'h1, 32'h1, 32'h1, 32'h1, 32'h1, 32'h10};
      issue(2'd2, 17'h0, 3'd3, 4'd1, 32'h0);
      wait_done("er", 200);
      chk("er_err", 32'(last_err), 32'd0);
      chk("er_ncsr", 32'(csr_wr_q.size()), 32'd3);
      chk("er_unprot", (csr_wr_q.size() > 0) ? csr_wr_q[0] : 32'h0, 32'hFDFF_FFFF);
      chk("er_ctrl", (csr_wr_q.size() > 1) ? csr_wr_q[1] : 32'h0, 32'hFDBF_FFFF);
      chk("er_reprot", (csr_wr_q.size() > 2) ? csr_wr_q[2] : 32'h0, 32'hFFFF_FFFF);
      chk("er_status_reads", 32'(csr_rd_cnt), 32'd13);

      // ERASE sector 1 ends idle without erase_ok (discarded sample says ok)
      clear(0, 32'h0);
      status_q = '{32'h0, 32'h10, 32'h0};
      issue(2'd2, 17'h0, 3'd1, 4'd1, 32'h0);
      wait_done("erf", 200);
      chk("erf_err", 32'(last_err), 32'd1);
      chk("erf_ctrl", (csr_wr_q.size() > 1) ? csr_wr_q[1] : 32'h0, 32'hFF1F_FFFF);
      chk("erf_reprot", (csr_wr_q.size() > 2) ? csr_wr_q[2] : 32'h0, 32'hFFFF_FFFF);

      // Status stuck busy: timeout after exactly 16 reads
      clear(0, 32'h0);
      status_q = '{32'h1};
      issue(2'd1, 17'h00010, 3'd5, 4'd1, 32'h1234_5678);
      wait_done("to", 300);
      chk("to_err", 32'(last_err), 32'd1);
      chk("to_status_reads", 32'(csr_rd_cnt), 32'd16);
      chk("to_ncsr", 32'(csr_wr_q.size()), 32'd1);
      chk("to_reprot", (csr_wr_q.size() > 0) ? csr_wr_q[0] : 32'h0, 32'hFFFF_FFFF);
      chk("to_no_data", 32'(acc_cnt), 32'd0);

      // Reset in the middle of a 7-beat read
      clear(0, 32'hB0);
      status_q = '{32'h0};
      issue(2'd0, 17'h00200, 3'd1, 4'd7, 32'h0);
      for (int i = 0; i < 50; i++) begin
         if (rd_q.size() >= 3) break;
         @(negedge clock);
         #2;
      end
      chk("rm_beats_before", 32'(rd_q.size()), 32'd3);
      reset = 1'b1;
      @(negedge clock);
      #2;
      chk("rm_strobes", 32'({avm_data_read, avm_data_write, avm_csr_read, avm_csr_write,
                              rd_valid, done}), 32'd0);
      chk("rm_ready", 32'(cmd_ready), 32'd1);
      reset = 1'b0;
      repeat (12) @(negedge clock);
      #2;
      chk("rm_no_done", 32'(done_cnt), 32'd0);
      chk("rm_beats_after", 32'(rd_q.size()), 32'd3);

      // Rejected commands: immediate error, no bus traffic
      for (int k = 0; k < 5; k++) begin
         clear(0, 32'h0);
         status_q = '{32'h0};
         issue(inv_op[k], 17'h0, inv_sec[k], inv_len[k], 32'h0);
         wait_done("inv", 20);
         chk("inv_err", 32'(last_err), 32'd1);
         chk("inv_bus", 32'(bus_act), 32'd0);
      end

      chk("overlap", 32'(overlap_cnt), 32'd0);
      chk("csr_addr", 32'(bad_addr), 32'd0);
      chk("err_without_done", 32'(err_nodone), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
